// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_pkg
// Description : Opcode/ALU encodings and the decoded-instruction record.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_ORR = 4'h8;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;

    // Field widths of the decoded record; the stage parameters must match these.
    localparam int DEC_ALU_OP_W = 3;
    localparam int DEC_REG_AW   = 4;
    localparam int DEC_IMM_W    = 16;

    typedef struct packed {
        logic                    alu_src;
        logic [DEC_ALU_OP_W-1:0] alu_op;
        logic [DEC_REG_AW-1:0]   rs1;
        logic [DEC_REG_AW-1:0]   rs2;
        logic [DEC_REG_AW-1:0]   rd;
        logic [DEC_IMM_W-1:0]    imm;
        logic                    reg_write;
        logic                    illegal;
    } decoded_t;

endpackage
`default_nettype wire

// File: rtl/decode_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : decode_scoreboard
// Description : Per-register pending bits with set/clear/flush-clear and a
//               three-address hazard lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_scoreboard #(
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_set_en,
    input  logic [REG_AW-1:0] i_set_addr,
    input  logic              i_clr_en,
    input  logic [REG_AW-1:0] i_clr_addr,
    input  logic              i_fl_en,
    input  logic [REG_AW-1:0] i_fl_addr,
    input  logic [REG_AW-1:0] i_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    input  logic [REG_AW-1:0] i_rd,
    output logic              o_hit,
    output logic              o_busy
);

    localparam int c_NREG = 2 ** REG_AW;

    logic [c_NREG-1:0] r_pending;
    logic [c_NREG-1:0] w_next;

    // A set on the same register as a clear wins, so a newly issued writer
    // is never lost to an older writeback retiring that register.
    always_comb begin
        w_next = r_pending;
        for (int i = 0; i < c_NREG; i++) begin
            if (i_set_en && (i_set_addr == REG_AW'(i))) begin
                w_next[i] = 1'b1;
            end else if ((i_clr_en && (i_clr_addr == REG_AW'(i))) ||
                         (i_fl_en  && (i_fl_addr  == REG_AW'(i)))) begin
                w_next[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_next;
        end
    end

    assign o_hit  = r_pending[i_rs1] | r_pending[i_rs2] | r_pending[i_rd];
    assign o_busy = |r_pending;

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Registered instruction-decode stage with valid/ready
//               handshake, RAW/WAW scoreboard, flush and stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
    import decode_pkg::*;
#(
    parameter  int INSTR_W  = 32,
    parameter  int REG_AW   = 4,
    parameter  int ALU_OP_W = 3,
    parameter  int CNT_W    = 16,
    localparam int IMM_W    = INSTR_W - 4 - 3 * REG_AW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INSTR_W-1:0]  in_instr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_alu_src,
    output logic [ALU_OP_W-1:0] out_alu_op,
    output logic [REG_AW-1:0]   out_rs1,
    output logic [REG_AW-1:0]   out_rs2,
    output logic [REG_AW-1:0]   out_rd,
    output logic [IMM_W-1:0]    out_imm,
    output logic                out_reg_write,
    output logic                out_illegal,
    input  logic                wb_valid,
    input  logic [REG_AW-1:0]   wb_rd,
    input  logic                flush,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic                busy
);

    if (ALU_OP_W != DEC_ALU_OP_W || REG_AW != DEC_REG_AW || IMM_W != DEC_IMM_W) begin : g_width_check
        $error("decode_stage: parameters do not match decoded_t field widths");
    end

    logic [3:0]       w_op;
    decoded_t         w_dec;
    decoded_t         r_dec;
    logic             r_valid;
    logic [CNT_W-1:0] r_cnt;
    logic             w_hit;
    logic             w_hazard;
    logic             w_accept;

    assign w_op = in_instr[INSTR_W-1 -: 4];

    always_comb begin
        w_dec           = '0;
        w_dec.rs1       = in_instr[INSTR_W-5 -: REG_AW];
        w_dec.rs2       = in_instr[INSTR_W-5-REG_AW -: REG_AW];
        w_dec.rd        = in_instr[INSTR_W-5-2*REG_AW -: REG_AW];
        w_dec.imm       = in_instr[IMM_W-1:0];
        w_dec.alu_src   = 1'b1;
        w_dec.reg_write = 1'b1;
        case (w_op)
            OP_ADD:  w_dec.alu_op = ALU_ADD;
            OP_SUB:  w_dec.alu_op = ALU_SUB;
            OP_AND:  w_dec.alu_op = ALU_AND;
            OP_ORR:  w_dec.alu_op = ALU_ORR;
            default: begin
                w_dec.alu_src   = 1'b0;
                w_dec.reg_write = 1'b0;
                w_dec.illegal   = (w_op != OP_NOP);
            end
        endcase
    end

    // Only writers stall; NOP/illegal carry no destination to protect.
    assign w_hazard = in_valid & w_dec.reg_write & w_hit;
    assign in_ready = ~rst & ~flush & ~w_hazard & (~r_valid | out_ready);
    assign w_accept = in_valid & in_ready;

    decode_scoreboard #(
        .REG_AW (REG_AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_set_en   (w_accept & w_dec.reg_write),
        .i_set_addr (w_dec.rd),
        .i_clr_en   (wb_valid),
        .i_clr_addr (wb_rd),
        .i_fl_en    (flush & r_valid & r_dec.reg_write),
        .i_fl_addr  (r_dec.rd),
        .i_rs1      (w_dec.rs1),
        .i_rs2      (w_dec.rs2),
        .i_rd       (w_dec.rd),
        .o_hit      (w_hit),
        .o_busy     (busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_dec   <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_dec   <= w_dec;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_hazard && !flush && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out_valid     = r_valid;
    assign out_alu_src   = r_dec.alu_src;
    assign out_alu_op    = r_dec.alu_op;
    assign out_rs1       = r_dec.rs1;
    assign out_rs2       = r_dec.rs2;
    assign out_rd        = r_dec.rd;
    assign out_imm       = r_dec.imm;
    assign out_reg_write = r_dec.reg_write;
    assign out_illegal   = r_dec.illegal;
    assign stall_cnt     = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Directed self-checking bench for decode_stage (CNT_W=4 so the
//               stall counter saturates quickly).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    localparam int c_CNT_W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic        out_alu_src;
    logic [2:0]  out_alu_op;
    logic [3:0]  out_rs1;
    logic [3:0]  out_rs2;
    logic [3:0]  out_rd;
    logic [15:0] out_imm;
    logic        out_reg_write;
    logic        out_illegal;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic        flush;
    logic [c_CNT_W-1:0] stall_cnt;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    decode_stage #(
        .INSTR_W  (32),
        .REG_AW   (4),
        .ALU_OP_W (3),
        .CNT_W    (c_CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_alu_src   (out_alu_src),
        .out_alu_op    (out_alu_op),
        .out_rs1       (out_rs1),
        .out_rs2       (out_rs2),
        .out_rd        (out_rd),
        .out_imm       (out_imm),
        .out_reg_write (out_reg_write),
        .out_illegal   (out_illegal),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .flush         (flush),
        .stall_cnt     (stall_cnt),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] rs1,
                                       input logic [3:0] rs2, input logic [3:0] rd,
                                       input logic [15:0] imm);
        return {op, rs1, rs2, rd, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
        wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
        step(); step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        rst = 1'b0;

        // ADD r3 = r1 + r2, imm 0x00AA
        in_valid = 1'b1; in_instr = mk(4'h2, 4'd1, 4'd2, 4'd3, 16'h00AA);
        #1 chk("add_in_ready", 32'(in_ready), 32'd1);
        step(); in_valid = 1'b0;
        chk("add_out_valid", 32'(out_valid),     32'd1);
        chk("add_alu_src",   32'(out_alu_src),   32'd1);
        chk("add_alu_op",    32'(out_alu_op),    32'd0);
        chk("add_rs1",       32'(out_rs1),       32'd1);
        chk("add_rs2",       32'(out_rs2),       32'd2);
        chk("add_rd",        32'(out_rd),        32'd3);
        chk("add_imm",       32'(out_imm),       32'h00AA);
        chk("add_reg_write", 32'(out_reg_write), 32'd1);
        chk("add_busy",      32'(busy),          32'd1);

        // SUB r8 = r3 - r0 stalls on r3; writeback of r3 in the 4th stall cycle
        in_valid = 1'b1; in_instr = mk(4'h4, 4'd3, 4'd0, 4'd8, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin wb_valid = 1'b1; wb_rd = 4'd3; end
            #1 chk("raw_stall_ready", 32'(in_ready), 32'd0);
            step();
        end
        wb_valid = 1'b0;
        chk("raw_stall_cnt", 32'(stall_cnt), 32'd4);
        #1 chk("raw_ready_after_wb", 32'(in_ready), 32'd1);
        step(); in_valid = 1'b0;
        chk("sub_out_valid", 32'(out_valid),  32'd1);
        chk("sub_alu_op",    32'(out_alu_op), 32'd1);
        chk("sub_rs1",       32'(out_rs1),    32'd3);
        chk("sub_rd",        32'(out_rd),     32'd8);
        wb_valid = 1'b1; wb_rd = 4'd8;
        step(); wb_valid = 1'b0;
        chk("wb8_busy",      32'(busy),       32'd0);
        chk("sub_drained",   32'(out_valid),  32'd0);

        // Back-to-back AND r5, ORR r6, then hold
        in_valid = 1'b1; in_instr = mk(4'h6, 4'd1, 4'd2, 4'd5, 16'h0011);
        #1 chk("and_in_ready", 32'(in_ready), 32'd1);
        step();
        chk("and_alu_op", 32'(out_alu_op), 32'd2);
        chk("and_rd",     32'(out_rd),     32'd5);
        in_instr = mk(4'h8, 4'd1, 4'd2, 4'd6, 16'h0022);
        #1 chk("orr_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("orr_alu_op", 32'(out_alu_op), 32'd3);
        chk("orr_rd",     32'(out_rd),     32'd6);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_valid",  32'(out_valid),  32'd1);
            chk("hold_alu_op", 32'(out_alu_op), 32'd3);
            chk("hold_rd",     32'(out_rd),     32'd6);
            chk("hold_imm",    32'(out_imm),    32'h0022);
        end
        out_ready = 1'b1;
        step();
        chk("orr_drained", 32'(out_valid), 32'd0);
        wb_valid = 1'b1; wb_rd = 4'd6;
        step(); wb_valid = 1'b0;
        chk("r5_still_busy", 32'(busy), 32'd1);

        // Illegal 0xF and NOP read pending r5 yet never stall
        in_valid = 1'b1; in_instr = mk(4'hF, 4'd5, 4'd0, 4'd0, 16'h0000);
        #1 chk("ill_in_ready", 32'(in_ready), 32'd1);
        step();
        chk("ill_illegal",   32'(out_illegal),   32'd1);
        chk("ill_alu_src",   32'(out_alu_src),   32'd0);
        chk("ill_reg_write", 32'(out_reg_write), 32'd0);
        chk("ill_rs1",       32'(out_rs1),       32'd5);
        in_instr = mk(4'h0, 4'd5, 4'd0, 4'd0, 16'h0000);
        #1 chk("nop_in_ready", 32'(in_ready), 32'd1);
        step(); in_valid = 1'b0;
        chk("nop_illegal",   32'(out_illegal), 32'd0);
        chk("nop_alu_src",   32'(out_alu_src), 32'd0);
        chk("nop_rs1",       32'(out_rs1),     32'd5);
        chk("nop_stall_cnt", 32'(stall_cnt),   32'd4);
        wb_valid = 1'b1; wb_rd = 4'd5;
        step(); wb_valid = 1'b0;
        chk("wb5_busy", 32'(busy), 32'd0);

        // Flush a held SUB r7
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = mk(4'h4, 4'd1, 4'd2, 4'd7, 16'h0000);
        step();
        chk("sub7_valid", 32'(out_valid), 32'd1);
        chk("sub7_busy",  32'(busy),      32'd1);
        flush = 1'b1; in_instr = mk(4'h2, 4'd0, 4'd0, 4'd9, 16'h0000);
        #1 chk("flush_in_ready", 32'(in_ready), 32'd0);
        step(); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_busy",      32'(busy),      32'd0);

        // Same-cycle writeback and accept of r4: set wins
        in_valid = 1'b1; in_instr = mk(4'h2, 4'd0, 4'd0, 4'd4, 16'h0000);
        wb_valid = 1'b1; wb_rd = 4'd4;
        step(); wb_valid = 1'b0;
        chk("setwin_busy", 32'(busy), 32'd1);
        in_instr = mk(4'h2, 4'd4, 4'd0, 4'd10, 16'h0000);
        #1 chk("setwin_hazard", 32'(in_ready), 32'd0);
        for (int i = 0; i < (2 ** c_CNT_W) + 3; i++) step();
        chk("stall_saturated", 32'(stall_cnt), 32'hF);

        // Reset in the middle of a stall
        rst = 1'b1;
        #1 chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
        step();
        chk("rst_mid_valid",     32'(out_valid),     32'd0);
        chk("rst_mid_busy",      32'(busy),          32'd0);
        chk("rst_mid_stall_cnt", 32'(stall_cnt),     32'd0);
        chk("rst_mid_rd",        32'(out_rd),        32'd0);
        chk("rst_mid_reg_write", 32'(out_reg_write), 32'd0);
        rst = 1'b0;
        #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
